nanorv32_console_tx: RTL and testbench

AHB-lite slave console transmitter on the nanorv32 data bus, downstream of the CPU's character output path. Firmware writes bytes to a data register; the block buffers them in a FIFO and serializes them as 8N1 frames on `tx`, with status, baud divisor and optional interrupt. It replaces the PC-match character capture with a synthesizable peripheral usable in both simulation and silicon.

---
 rtl/nanorv32_console_tx_pkg.sv | 30 +++
 rtl/nanorv32_console_fifo.sv | 61 ++++++
 rtl/nanorv32_console_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_nanorv32_console_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanorv32_console_tx_pkg.sv
// Shared register map, STATUS/CTRL bit positions and serializer state encoding
// for the nanorv32 console transmitter.
package nanorv32_console_tx_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // A programmed divisor of zero would never advance the bit timer.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/nanorv32_console_fifo.sv
// Synchronous FIFO buffering console bytes between the bus and the serializer.
module nanorv32_console_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/nanorv32_console_tx.sv
// AHB-lite console transmitter: byte FIFO feeding an 8N1 serializer.
// Define NANORV32_CONSOLE_IRQ_EN to implement CTRL.irq_en and the irq output.
module nanorv32_console_tx
    import nanorv32_console_tx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsel,
    input  logic [3:0]  haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]  addr_q, addr_d;
    logic        write_q, write_d;
    logic        valid_q, valid_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic        ovf_q, ovf_d;
    logic [15:0] baud_q, baud_d;
    logic        en_q, en_d;
    logic        irq_en;
`ifdef NANORV32_CONSOLE_IRQ_EN
    logic        irq_en_q, irq_en_d;
`endif

    logic          ap_valid, wr_en, busy;
    logic [31:0]   status_word, ctrl_word;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;

    tx_state_e   state_q, state_d;
    logic        tx_q, tx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;

    logic unused_ok;
    assign unused_ok = ^{haddr[1:0], htrans[0], hwdata[31:16], fifo_count};

`ifdef NANORV32_CONSOLE_IRQ_EN
    assign irq_en = irq_en_q;
`else
    assign irq_en = 1'b0;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign hrdata    = hrdata_q;
    assign hreadyout = 1'b1;
    assign hresp     = 1'b0;
    assign tx        = tx_q;
    assign irq       = irq_en & fifo_empty & ~busy;

    nanorv32_console_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (hwdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Bus side: address phase is captured, the write lands at the end of the data phase.
    always_comb begin
        ap_valid = hsel & hready & htrans[1];
        addr_d   = haddr[3:2];
        write_d  = hwrite;
        valid_d  = ap_valid;

        wr_en     = valid_q & write_q;
        fifo_push = wr_en & (addr_q == REG_DATA) & ~fifo_full;

        ovf_d = ovf_q;
        if (wr_en && addr_q == REG_STATUS && hwdata[STAT_OVF]) ovf_d = 1'b0;
        if (wr_en && addr_q == REG_DATA && fifo_full)          ovf_d = 1'b1;

        baud_d = (wr_en && addr_q == REG_BAUD) ? hwdata[15:0] : baud_q;
        en_d   = (wr_en && addr_q == REG_CTRL) ? hwdata[CTRL_EN] : en_q;
`ifdef NANORV32_CONSOLE_IRQ_EN
        irq_en_d = (wr_en && addr_q == REG_CTRL) ? hwdata[CTRL_IRQ_EN] : irq_en_q;
`endif

        status_word             = '0;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_BUSY]  = busy;
        status_word[STAT_OVF]   = ovf_q;
        ctrl_word               = '0;
        ctrl_word[CTRL_EN]      = en_q;
        ctrl_word[CTRL_IRQ_EN]  = irq_en;

        hrdata_d = '0;
        if (ap_valid && !hwrite) begin
            case (haddr[3:2])
                REG_STATUS: hrdata_d = status_word;
                REG_BAUD:   hrdata_d = {16'd0, baud_q};
                REG_CTRL:   hrdata_d = ctrl_word;
                default:    hrdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= REG_DATA;
            write_q  <= 1'b0;
            valid_q  <= 1'b0;
            hrdata_q <= '0;
            ovf_q    <= 1'b0;
            baud_q   <= 16'(DEFAULT_DIV);
            en_q     <= 1'b0;
`ifdef NANORV32_CONSOLE_IRQ_EN
            irq_en_q <= 1'b0;
`endif
        end else begin
            addr_q   <= addr_d;
            write_q  <= write_d;
            valid_q  <= valid_d;
            hrdata_q <= hrdata_d;
            ovf_q    <= ovf_d;
            baud_q   <= baud_d;
            en_q     <= en_d;
`ifdef NANORV32_CONSOLE_IRQ_EN
            irq_en_q <= irq_en_d;
`endif
        end
    end

    // Serializer: each state/bit holds for div_q cycles; a pop in the last STOP cycle
    // chains straight into the next START so queued frames run back to back.
    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (en_q && !fifo_empty) fifo_pop = 1'b1;
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                    cnt_d   = div_q - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = div_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (en_q && !fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        if (fifo_pop) begin
            state_d = ST_START;
            tx_d    = 1'b0;
            div_d   = eff_div(baud_q);
            cnt_d   = eff_div(baud_q) - 16'd1;
            shift_d = fifo_rdata;
            bit_d   = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            cnt_q   <= '0;
            div_q   <= 16'd1;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: tb/tb_nanorv32_console_tx.sv
// Directed bench for nanorv32_console_tx: register vector table plus hand-written
// frame, overflow, irq and reset sequences.
module tb_nanorv32_console_tx;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        hsel   = 1'b0;
    logic [3:0]  haddr  = '0;
    logic [1:0]  htrans = '0;
    logic        hwrite = 1'b0;
    logic        hready = 1'b1;
    logic [31:0] hwdata = '0;
    logic [31:0] hrdata;
    logic        hreadyout, hresp, tx, irq;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

`ifdef NANORV32_CONSOLE_IRQ_EN
    localparam logic [31:0] CTRL_ALL = 32'h3;
`else
    localparam logic [31:0] CTRL_ALL = 32'h1;
`endif

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    nanorv32_console_tx #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hready    (hready),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .tx        (tx),
        .irq       (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns at the negedge inside the data-phase cycle; the write lands at the next posedge.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00;
        d = hrdata;
    endtask

    // Waits for a start bit, samples each bit mid-period, returns at the stop-bit sample.
    task automatic recv_byte(input int div, output logic [7:0] b, output int t0);
        int w;
        w = 0;
        b = '0;
        @(negedge clk);
        while (tx !== 1'b0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        t0 = cyc;
        check("start_seen", 32'(w < 400), 32'd1);
        repeat (div + div / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            b[k] = tx;
            if (k < 7) repeat (div) @(negedge clk);
        end
        repeat (div) @(negedge clk);
        check("stop_bit", {31'd0, tx}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        int          t0, t_prev;
        bit          tx_hi;
        logic [31:0] exp_bit;
        vec_t        vecs[16];

        vecs[0]  = '{1'b0, 4'h4, 32'h0,        32'h2};
        vecs[1]  = '{1'b0, 4'h8, 32'h0,        32'd16};
        vecs[2]  = '{1'b0, 4'hC, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 4'h0, 32'h0,        32'h0};
        vecs[4]  = '{1'b1, 4'h8, 32'hFFFF1234, 32'h0};
        vecs[5]  = '{1'b0, 4'h8, 32'h0,        32'h1234};
        vecs[6]  = '{1'b1, 4'hC, 32'hFFFFFFFF, 32'h0};
        vecs[7]  = '{1'b0, 4'hC, 32'h0,        CTRL_ALL};
        vecs[8]  = '{1'b1, 4'hC, 32'h0,        32'h0};
        vecs[9]  = '{1'b0, 4'hC, 32'h0,        32'h0};
        vecs[10] = '{1'b1, 4'h8, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 4'h8, 32'h0,        32'h0};
        vecs[12] = '{1'b1, 4'h4, 32'h8,        32'h0};
        vecs[13] = '{1'b0, 4'h4, 32'h0,        32'h2};
        vecs[14] = '{1'b1, 4'h8, 32'd16,       32'h0};
        vecs[15] = '{1'b0, 4'h8, 32'h0,        32'd16};

        repeat (2) @(negedge clk);
        check("rst_tx",        {31'd0, tx},        32'd1);
        check("rst_irq",       {31'd0, irq},       32'd0);
        check("rst_hrdata",    hrdata,             32'd0);
        check("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
        check("rst_hresp",     {31'd0, hresp},     32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d", i), rd, vecs[i].exp);
            end
        end

        // Single 0x55 frame at BAUD=4 checked cycle by cycle, with a STATUS read mid-frame.
        bus_write(4'h8, 32'd4);
        bus_write(4'hC, 32'h1);
        bus_write(4'h0, 32'h55);
        @(negedge clk);
        check("tx_before_start", {31'd0, tx}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i < 4)       exp_bit = 32'd0;
            else if (i >= 36) exp_bit = 32'd1;
            else             exp_bit = (32'h55 >> ((i / 4) - 1)) & 32'd1;
            check($sformatf("frame55_c%0d", i), {31'd0, tx}, exp_bit);
            if (i == 5) begin
                hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 4'h4;
            end
            if (i == 6) begin
                hsel = 1'b0; htrans = 2'b00;
                check("status_midframe", hrdata, 32'h6);
            end
        end
        @(negedge clk);
        check("tx_after_frame", {31'd0, tx}, 32'd1);
        bus_read(4'h4, rd);
        check("status_after_frame", rd, 32'h2);

        // Three queued bytes at BAUD=2 must leave as contiguous 20-cycle frames.
        bus_write(4'hC, 32'h0);
        bus_write(4'h8, 32'd2);
        for (int i = 0; i < 3; i++) bus_write(4'h0, 32'h31 + 32'(i));
        bus_read(4'h4, rd);
        check("status_queued3", rd, 32'h0);
        bus_write(4'hC, 32'h1);
        t_prev = 0;
        for (int i = 0; i < 3; i++) begin
            recv_byte(2, b, t0);
            check($sformatf("b2b_byte%0d", i), {24'd0, b}, 32'h31 + 32'(i));
            if (i > 0) check($sformatf("b2b_gap%0d", i), 32'(t0 - t_prev), 32'd20);
            t_prev = t0;
        end
        bus_read(4'h4, rd);
        check("status_after_b2b", rd, 32'h2);

        // BAUD=0 behaves as a one-cycle bit.
        bus_write(4'h8, 32'd0);
        bus_write(4'h0, 32'h3C);
        recv_byte(1, b, t0);
        check("baud0_byte", {24'd0, b}, 32'h3C);

        // Fill, overflow, sticky clear, then drain without the dropped ninth byte.
        bus_write(4'hC, 32'h0);
        bus_write(4'h8, 32'd2);
        for (int i = 0; i < 7; i++) bus_write(4'h0, 32'hA0 + 32'(i));
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 4'h0;
        @(negedge clk);
        hwrite = 1'b0; haddr = 4'h4; hwdata = 32'hA7;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00;
        check("status_prepush", hrdata, 32'h0);
        bus_read(4'h4, rd);
        check("status_full", rd, 32'h1);
        bus_write(4'h0, 32'hA8);
        bus_read(4'h4, rd);
        check("status_overflow", rd, 32'h9);
        bus_write(4'h4, 32'h8);
        bus_read(4'h4, rd);
        check("overflow_clear", rd, 32'h1);
        bus_write(4'hC, 32'h1);
        for (int i = 0; i < 8; i++) begin
            recv_byte(2, b, t0);
            check($sformatf("drain%0d", i), {24'd0, b}, 32'hA0 + 32'(i));
        end
        tx_hi = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_hi = 1'b0;
        end
        check("ninth_not_sent", {31'd0, tx_hi}, 32'd1);
        bus_read(4'h4, rd);
        check("status_drained", rd, 32'h2);

`ifdef NANORV32_CONSOLE_IRQ_EN
        bus_write(4'hC, 32'h3);
        @(negedge clk);
        check("irq_idle_empty", {31'd0, irq}, 32'd1);
        bus_write(4'h0, 32'h5A);
        check("irq_before_push", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq_after_push", {31'd0, irq}, 32'd0);
        recv_byte(2, b, t0);
        check("irq_byte", {24'd0, b}, 32'h5A);
        check("irq_in_stop", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_frame_done", {31'd0, irq}, 32'd1);
        bus_write(4'h0, 32'h11);
        @(negedge clk);
        check("irq_next_write", {31'd0, irq}, 32'd0);
        recv_byte(2, b, t0);
        check("irq_byte2", {24'd0, b}, 32'h11);
`else
        bus_write(4'hC, 32'h3);
        @(negedge clk);
        check("irq_tied_low", {31'd0, irq}, 32'd0);
        bus_read(4'hC, rd);
        check("ctrl_no_irq_en", rd, 32'h1);
`endif
        bus_write(4'hC, 32'h0);

        // Asynchronous reset in the middle of a data bit, with a second byte still queued.
        bus_write(4'h8, 32'd4);
        bus_write(4'hC, 32'h1);
        bus_write(4'h0, 32'h00);
        bus_write(4'h0, 32'h00);
        repeat (5) @(negedge clk);
        check("tx_mid_data", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("tx_async_reset", {31'd0, tx}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_read(4'h4, rd);
        check("status_after_reset", rd, 32'h2);
        bus_read(4'h8, rd);
        check("baud_after_reset", rd, 32'd16);
        bus_read(4'hC, rd);
        check("ctrl_after_reset", rd, 32'h0);
        tx_hi = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_hi = 1'b0;
        end
        check("tx_idle_after_reset", {31'd0, tx_hi}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
